accum_array: RTL and testbench

//  Count table downstream of search_and_add. Consumes the accum_addr/accum_din/accum_we stream and adds accum_din into a

---
 rtl/accum_array.sv | 223 ++++++++++++++++++++++
 tb/tb_accum_array.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/accum_array.sv
// Saturating 64-bit count table: read-modify-write update stream,
// bulk clear and AXI4-Stream drain of every entry in index order.
module accum_array #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int CLEAR_ON_RD = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] accum_addr,
  input  logic [63:0] accum_din,
  input  logic        accum_we,
  input  logic        clear_kick,
  input  logic        drain_kick,
  output logic        busy,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        err_range,
  output logic        err_drop
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

  localparam logic [31:0]       DEPTH32 = 32'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [63:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic [63:0]         s1_din_q, s1_din_d;
  logic                fwd_q, fwd_d;
  logic [63:0]         fwd_data_q, fwd_data_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic                iss_q, iss_d;
  logic [ADDR_W-1:0]   iss_idx_q, iss_idx_d;
  logic                out_valid_q, out_valid_d;
  logic [63:0]         out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
  logic                skid_valid_q, skid_valid_d;
  logic [63:0]         skid_data_q, skid_data_d;
  logic                skid_last_q, skid_last_d;
  logic [ADDR_W-1:0]   skid_idx_q, skid_idx_d;
  logic                err_range_q, err_range_d;
  logic                err_drop_q, err_drop_d;
  logic [63:0]         ram_rdata_q;

  logic              in_range, s0_acc, hs, issue, arr_last;
  logic [63:0]       old, s1_sum;
  logic [1:0]        occ, occ_n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [63:0]       mem_wdata;

  assign in_range = accum_addr < DEPTH32;
  assign s0_acc   = accum_we && in_range && (state_q == IDLE);
  assign old      = fwd_q ? fwd_data_q : ram_rdata_q;
  // old + din overflows exactly when old > (2^64-1) - din
  assign s1_sum   = (old > ~s1_din_q) ? '1 : old + s1_din_q;
  assign hs       = out_valid_q && m_axis_tready;
  assign arr_last = iss_idx_q == LAST;
  assign occ      = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, iss_q};
  assign occ_n    = occ - {1'b0, hs};
  assign issue    = (state_q == DRAIN) && !s1_valid_q &&
                    !rd_ptr_q[ADDR_W] && (occ_n <= 2'd1);

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    clr_idx_d    = '0;
    s1_valid_d   = s0_acc;
    s1_addr_d    = accum_addr[ADDR_W-1:0];
    s1_din_d     = accum_din;
    fwd_d        = s0_acc && s1_valid_q &&
                   (accum_addr[ADDR_W-1:0] == s1_addr_q);
    fwd_data_d   = s1_sum;
    rd_ptr_d     = '0;
    iss_d        = 1'b0;
    iss_idx_d    = iss_idx_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_idx_d    = out_idx_q;
    skid_valid_d = 1'b0;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_idx_d   = skid_idx_q;
    err_range_d  = err_range_q | (accum_we && !in_range);
    err_drop_d   = err_drop_q | (accum_we && (state_q != IDLE));
    mem_we       = s1_valid_q;
    mem_waddr    = s1_addr_q;
    mem_wdata    = s1_sum;
    mem_raddr    = accum_addr[ADDR_W-1:0];
    unique case (state_q)
      IDLE: begin
        if (clear_kick) begin
          state_d = CLEAR;
          pend_d  = drain_kick;
        end else if (drain_kick) begin
          state_d = DRAIN;
        end
      end
      CLEAR: begin
        clr_idx_d = clr_idx_q;
        if (!s1_valid_q) begin
          mem_we    = 1'b1;
          mem_waddr = clr_idx_q;
          mem_wdata = '0;
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == LAST) begin
            state_d = pend_q ? DRAIN : IDLE;
            pend_d  = 1'b0;
          end
        end
      end
      DRAIN: begin
        mem_raddr    = rd_ptr_q[ADDR_W-1:0];
        rd_ptr_d     = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        iss_d        = issue;
        iss_idx_d    = rd_ptr_q[ADDR_W-1:0];
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        // Output stage refills from skid first, then from the RAM read
        if (!out_valid_q || hs) begin
          if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            out_idx_d    = skid_idx_q;
            skid_valid_d = iss_q;
            skid_data_d  = ram_rdata_q;
            skid_last_d  = arr_last;
            skid_idx_d   = iss_idx_q;
          end else begin
            out_valid_d = iss_q;
            out_data_d  = ram_rdata_q;
            out_last_d  = arr_last;
            out_idx_d   = iss_idx_q;
          end
        end else if (iss_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = ram_rdata_q;
          skid_last_d  = arr_last;
          skid_idx_d   = iss_idx_q;
        end
        if (hs && (CLEAR_ON_RD != 0)) begin
          mem_we    = 1'b1;
          mem_waddr = out_idx_q;
          mem_wdata = '0;
        end
        if (hs && out_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_rdata_q <= mem[mem_raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      clr_idx_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_din_q     <= '0;
      fwd_q        <= 1'b0;
      fwd_data_q   <= '0;
      rd_ptr_q     <= '0;
      iss_q        <= 1'b0;
      iss_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_idx_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_idx_q   <= '0;
      err_range_q  <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      clr_idx_q    <= clr_idx_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_din_q     <= s1_din_d;
      fwd_q        <= fwd_d;
      fwd_data_q   <= fwd_data_d;
      rd_ptr_q     <= rd_ptr_d;
      iss_q        <= iss_d;
      iss_idx_q    <= iss_idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_idx_q    <= out_idx_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_idx_q   <= skid_idx_d;
      err_range_q  <= err_range_d;
      err_drop_q   <= err_drop_d;
    end
  end

  assign busy          = (state_q != IDLE) || s1_valid_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_valid_q && out_last_q;
  assign err_range     = err_range_q;
  assign err_drop      = err_drop_q;

endmodule

// File: tb/tb_accum_array.sv
// Bench for accum_array: random update bursts against an array model,
// drains under several tready patterns, clear, errors and async reset.
module tb_accum_array;

  localparam int DEPTH = 1024;
  localparam logic [63:0] MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] accum_addr = '0;
  logic [63:0] accum_din = '0;
  logic        accum_we = 1'b0;
  logic        clear_kick = 1'b0;
  logic        drain_kick = 1'b0;
  logic        busy;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        err_range;
  logic        err_drop;

  int checks = 0;
  int fails  = 0;
  logic [63:0] model [DEPTH];

  accum_array #(.DEPTH(DEPTH), .ADDR_W(10), .CLEAR_ON_RD(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .accum_addr(accum_addr), .accum_din(accum_din),
    .accum_we(accum_we), .clear_kick(clear_kick),
    .drain_kick(drain_kick), .busy(busy),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .err_range(err_range), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sat(input logic [63:0] a,
                                      input logic [63:0] b);
    return (a > MAX - b) ? MAX : a + b;
  endfunction

  task automatic upd(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    accum_we = 1'b1;
    accum_addr = a;
    accum_din = d;
    if (a < DEPTH) model[a] = sat(model[a], d);
  endtask

  task automatic we_off(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      accum_we = 1'b0;
    end
  endtask

  task automatic burst(input int n, input int amax, input bit big);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = big ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
      upd(32'($urandom_range(0, amax)), d);
      if ($urandom_range(0, 3) == 0) we_off($urandom_range(1, 2));
    end
    we_off(3);
  endtask

  task automatic do_clear();
    int cnt = 0;
    @(negedge clk);
    clear_kick = 1'b1;
    @(negedge clk);
    clear_kick = 1'b0;
    while (busy && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
    chk("clear_busy_len", 64'(cnt >= DEPTH && cnt <= DEPTH + 2), 64'd1);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // mode 0: tready=1, 1: 1,0,0,1 pattern, 2: random
  task automatic drain(input int mode, input bit both,
                       input int abort_at, input bit inject);
    int beats = 0;
    int cyc = 0;
    bit stall = 0;
    bit done = 0;
    bit injected = 0;
    bit rdy;
    logic [63:0] sd;
    logic sl;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    m_axis_tready = 1'b0;
    drain_kick = 1'b1;
    clear_kick = both;
    if (both) for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(negedge clk);
    drain_kick = 1'b0;
    clear_kick = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && beats == abort_at) begin
        m_axis_tready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_tlast", 64'(m_axis_tlast), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_err_drop", 64'(err_drop), 64'd0);
        return;
      end
      if (stall) begin
        chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_tdata", m_axis_tdata, sd);
        chk("stall_tlast", 64'(m_axis_tlast), 64'(sl));
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_axis_tready = rdy;
      accum_we = 1'b0;
      if (inject && !injected && beats >= 100) begin
        injected = 1;
        accum_we = 1'b1;
        accum_addr = 32'd3;
        accum_din = 64'd9;
      end
      stall = m_axis_tvalid && !rdy;
      sd = m_axis_tdata;
      sl = m_axis_tlast;
      if (m_axis_tvalid && rdy) begin
        chk($sformatf("beat%0d_data", beats), m_axis_tdata, model[beats]);
        chk($sformatf("beat%0d_last", beats), 64'(m_axis_tlast),
            64'(beats == DEPTH - 1));
        model[beats] = '0;
        beats++;
        if (beats == DEPTH) done = 1;
      end
      if (cyc > 8000) begin
        chk("drain_timeout", 64'(beats), 64'(DEPTH));
        done = 1;
      end
    end
    @(negedge clk);
    m_axis_tready = 1'b0;
    accum_we = 1'b0;
    chk("post_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_err_range", 64'(err_range), 64'd0);
    chk("rst_err_drop", 64'(err_drop), 64'd0);
    reset_n = 1'b1;

    do_clear();
    drain(0, 0, -1, 0);

    for (int i = 0; i < 8; i++) upd(32'd5, 64'd1);
    we_off(3);
    chk("fwd_model5", model[5], 64'd8);
    drain(0, 0, -1, 0);

    upd(32'd7, MAX - 64'd1);
    upd(32'd7, 64'd5);
    upd(32'd9, MAX - 64'd3);
    we_off(1);
    upd(32'd9, 64'd2);
    we_off(2);
    upd(32'd9, 64'd7);
    we_off(3);
    drain(2, 0, -1, 0);

    burst(300, 15, 0);
    burst(60, 7, 1);
    drain(1, 0, -1, 0);
    drain(1, 0, -1, 0);

    upd(32'd1024, 64'd1);
    upd(32'h8000_0005, 64'd1);
    we_off(1);
    chk("err_range_set", 64'(err_range), 64'd1);
    chk("err_drop_clr", 64'(err_drop), 64'd0);
    burst(100, 1023, 0);
    drain(2, 0, -1, 1);
    chk("err_drop_set", 64'(err_drop), 64'd1);

    burst(50, 1023, 1);
    drain(0, 1, -1, 0);

    burst(400, 1023, 0);
    drain(0, 0, 300, 0);
    chk("after_rst_err_range", 64'(err_range), 64'd0);
    chk("after_rst_busy", 64'(busy), 64'd0);
    drain(2, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
